mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Sequential successor to the single-cycle MIPS decoder. It is a multicycle control FSM that decodes opcode/funct from a latched instruction register. It sequences fetch, decode, execute, memory and writeback over several cycles against a waitrequest-style memory bus. It also interlocks with an iterative MULT/DIV unit and generates per-state datapath strobes, byte enables and a halt condition.

Parameters:
BYTE_LANES, 4, number of byte enables on the data bus; must be 4 for the 32-bit datapath.
SUPPORT_MULDIV, 1, when 0, MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO decode as illegal.
HALT_ON_ZERO_JR, 1, when 1, a JR whose target is 0 enters HALT.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
instr  input  32  fetched word from the bus; captured on ir_write
mem_waitrequest  input  1  bus stall; current access holds while 1
addr_lo  input  2  effective address bits [1:0] from the ALU (valid in EXEC/MEM)
muldiv_busy  input  1  iterative MULT/DIV unit still computing
jr_target_zero  input  1  rs value equals 0 (valid in EXEC)
active  output  1  high from reset release until HALT
state  output  4  current FSM state code (debug)
ir_write, pc_write, iord  output  1 each  IR load, PC update, bus address select (0 = PC, 1 = ALU)
mem_read, mem_write  output  1 each  bus strobes
mem_byteenable  output  BYTE_LANES  lane enables for stores; all ones for reads
jr, jump, branch, link  output  1 each  next-PC select / link write ($31 or rd for JALR)
reg_write, reg_dst, mem_to_reg  output  1 each  regfile write strobe, rd(1)/rt(0) select, load data select
write_hi, write_lo, read_hi_lo, muldiv_start  output  1 each  HI/LO write strobes, MFHI/MFLO select, one-cycle muldiv launch
illegal  output  1  sticky flag: an undecodable instruction was seen

Behaviour:
- Reset (async, reset_n=0): state=FETCH; every output 0 except active=1 and mem_byteenable=0. illegal clears. Reset mid-access drops strobes immediately; no partial writeback.
- States: FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4), MD_WAIT(5), HALT(6).
- FETCH: iord=0, mem_read=1, byteenable=4'hF. Stay while mem_waitrequest=1. On 0: ir_write=1, pc_write=1 (PC+4), then DECODE.
- DECODE: decode IR[31:26], IR[5:0]. Any HI/LO access (MFHI/MFLO/MTHI/MTLO/MULT*/DIV*) with muldiv_busy=1 stays in DECODE (stall). Otherwise go to EXEC.
- EXEC:
  - R-type ALU, I-type ALU, LUI: next WB.
  - BEQ/BNE: branch=1, then FETCH.
  - J: jump=1, pc_write=1, then FETCH.
  - JAL: jump=1, pc_write=1, link=1, reg_write=1, then FETCH.
  - JR: jr=1, pc_write=1. If HALT_ON_ZERO_JR and jr_target_zero, go to HALT; else FETCH.
  - JALR: jr=1, pc_write=1, link=1, reg_dst=1, reg_write=1, then FETCH.
  - MULT/MULTU/DIV/DIVU: muldiv_start=1 for exactly one cycle, then MD_WAIT.
  - MTHI: write_hi=1, then FETCH. MTLO: write_lo=1, then FETCH.
  - MFHI/MFLO: read_hi_lo=1, reg_dst=1, reg_write=1, then FETCH.
  - Loads and stores: next MEM.
  - Illegal opcode/funct: set illegal, behave as NOP, then FETCH.
- MD_WAIT: stay while muldiv_busy=1. When clear, pulse write_hi=write_lo=1 for one cycle, then FETCH.
- MEM: iord=1. Hold all strobes and byteenable stable while mem_waitrequest=1.
  - Store: mem_write=1. SW -> 4'hF (addr_lo must be 0). SH -> 4'b0011 (addr_lo=0) or 4'b1100 (addr_lo=2). SB -> one-hot 1<<addr_lo. Misaligned SW/SH sets illegal and performs no write. On release, go to FETCH.
  - Load: mem_read=1, byteenable=4'hF. On release, go to WB.
- WB: reg_write=1. reg_dst=1 for R-type, else 0. mem_to_reg=1 for loads. Then FETCH.
- HALT: active=0, all strobes 0. Absorbing until reset.
- Latency with zero wait states: ALU op 4 cycles, load 5, store 4, branch/jump 3, MULT/DIV 4 + busy cycles. Each bus wait cycle adds 1.
- All strobes are Moore outputs of the state plus the registered IR. They must be glitch-free, with no combinational path from the inputs except the stall holds.

Test Plan:
- Reset release, ADDU $3,$1,$2 (0x00221821), no waits -> FETCH,DECODE,EXEC,WB. reg_write=1 and reg_dst=1 only in cycle 4. active=1.
- LW with mem_waitrequest high 3 cycles in MEM -> mem_read/iord held 3 cycles. WB one cycle after release with mem_to_reg=1, reg_dst=0. Total 8 cycles.
- SB at addr_lo=2'b10 -> mem_byteenable=4'b0100. SH at addr_lo=2'b01 -> illegal=1, mem_write never asserted.
- MULT then MFHI, muldiv_busy high 5 cycles -> muldiv_start one pulse. write_hi/write_lo pulse together once busy falls. MFHI stalls in DECODE until then.
- JR $0 with jr_target_zero=1 -> pc_write=1 in EXEC, then HALT with active=0. reset_n low mid-HALT -> FETCH immediately, asynchronously.
- Undefined opcode 0x3F -> illegal=1 sticky, next instruction fetched normally 3 cycles later.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/exec/mem/writeback
// against a waitrequest bus, interlocks with an iterative MULT/DIV unit and
// drives Moore-style datapath strobes from the state and the latched IR.
module mips_multicycle_ctrl #(
  parameter int unsigned BYTE_LANES      = 4,
  parameter int unsigned SUPPORT_MULDIV  = 1,
  parameter int unsigned HALT_ON_ZERO_JR = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           instr,
  input  logic                  mem_waitrequest,
  input  logic [1:0]            addr_lo,
  input  logic                  muldiv_busy,
  input  logic                  jr_target_zero,
  output logic                  active,
  output logic [3:0]            state,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  iord,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [BYTE_LANES-1:0] mem_byteenable,
  output logic                  jr,
  output logic                  jump,
  output logic                  branch,
  output logic                  link,
  output logic                  reg_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  write_hi,
  output logic                  write_lo,
  output logic                  read_hi_lo,
  output logic                  muldiv_start,
  output logic                  illegal
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_EXEC    = 4'd2;
  localparam logic [3:0] S_MEM     = 4'd3;
  localparam logic [3:0] S_WB      = 4'd4;
  localparam logic [3:0] S_MD_WAIT = 4'd5;
  localparam logic [3:0] S_HALT    = 4'd6;

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [5:0] op_q, fn_q;
  logic [1:0] alo_q;
  logic       ir_load;

  // Only opcode and funct steer control; the operand fields belong to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:6];

  logic d_ralu, d_ialu, d_br, d_j, d_jal, d_jr, d_jalr, d_hilo;
  logic d_load, d_sw, d_sh, d_sb, d_ill;
  logic d_md, d_mthi, d_mtlo, d_mfhi, d_mflo, d_store, mis_store;
  logic [BYTE_LANES-1:0] st_be;

  assign ir_load = (state_q == S_FETCH) && !mem_waitrequest;

  // Classify the latched instruction into control groups.
  always_comb begin
    d_ralu = 1'b0; d_ialu = 1'b0; d_br = 1'b0; d_j = 1'b0; d_jal = 1'b0;
    d_jr = 1'b0; d_jalr = 1'b0; d_hilo = 1'b0; d_load = 1'b0;
    d_sw = 1'b0; d_sh = 1'b0; d_sb = 1'b0; d_ill = 1'b0;
    case (op_q)
      6'h00: begin
        case (fn_q)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
          6'h26, 6'h27, 6'h2A, 6'h2B:                   d_ralu = 1'b1;
          6'h08:                                        d_jr   = 1'b1;
          6'h09:                                        d_jalr = 1'b1;
          6'h10, 6'h11, 6'h12, 6'h13,
          6'h18, 6'h19, 6'h1A, 6'h1B: begin
            if (SUPPORT_MULDIV != 0) d_hilo = 1'b1;
            else                     d_ill  = 1'b1;
          end
          default:                                      d_ill  = 1'b1;
        endcase
      end
      6'h02:                                            d_j    = 1'b1;
      6'h03:                                            d_jal  = 1'b1;
      6'h04, 6'h05:                                     d_br   = 1'b1;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
      6'h0E, 6'h0F:                                     d_ialu = 1'b1;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25:                d_load = 1'b1;
      6'h28:                                            d_sb   = 1'b1;
      6'h29:                                            d_sh   = 1'b1;
      6'h2B:                                            d_sw   = 1'b1;
      default:                                          d_ill  = 1'b1;
    endcase
  end

  assign d_md      = d_hilo && fn_q[3];
  assign d_mfhi    = d_hilo && (fn_q == 6'h10);
  assign d_mthi    = d_hilo && (fn_q == 6'h11);
  assign d_mflo    = d_hilo && (fn_q == 6'h12);
  assign d_mtlo    = d_hilo && (fn_q == 6'h13);
  assign d_store   = d_sw || d_sh || d_sb;
  assign mis_store = (d_sw && (alo_q != 2'b00)) || (d_sh && alo_q[0]);

  // Store lane enables from the address captured in EXEC, so MEM outputs stay Moore.
  always_comb begin
    st_be = '0;
    if (d_sw)      st_be = '1;
    else if (d_sh) st_be = alo_q[1] ? BYTE_LANES'(4'b1100) : BYTE_LANES'(4'b0011);
    else if (d_sb) st_be = BYTE_LANES'(1) << alo_q;
  end

  // Next-state and sticky illegal-flag logic.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:   if (!mem_waitrequest) state_d = S_DECODE;
      S_DECODE:  if (!(d_hilo && muldiv_busy)) state_d = S_EXEC;
      S_EXEC: begin
        if (d_ill) illegal_d = 1'b1;
        if (d_ralu || d_ialu)             state_d = S_WB;
        else if (d_load || d_store)       state_d = S_MEM;
        else if (d_md)                    state_d = S_MD_WAIT;
        else if (d_jr && (HALT_ON_ZERO_JR != 0) && jr_target_zero)
                                          state_d = S_HALT;
        else                              state_d = S_FETCH;
      end
      S_MEM: begin
        // A misaligned store never touches the bus, so it does not wait on it.
        if (mis_store) begin
          illegal_d = 1'b1;
          state_d   = S_FETCH;
        end else if (!mem_waitrequest) begin
          state_d = d_load ? S_WB : S_FETCH;
        end
      end
      S_WB:      state_d = S_FETCH;
      S_MD_WAIT: if (!muldiv_busy) state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  // State, IR fields, captured address and sticky illegal flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      op_q      <= '0;
      fn_q      <= '0;
      alo_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (ir_load) begin
        op_q <= instr[31:26];
        fn_q <= instr[5:0];
      end
      if (state_q == S_EXEC) alo_q <= addr_lo;
    end
  end

  assign state   = state_q;
  assign active  = (state_q != S_HALT);
  assign illegal = illegal_q;

  // Per-state strobes; reset_n gating drops them the moment reset asserts.
  always_comb begin
    ir_write = 1'b0; pc_write = 1'b0; iord = 1'b0; mem_read = 1'b0;
    mem_write = 1'b0; mem_byteenable = '0; jr = 1'b0; jump = 1'b0;
    branch = 1'b0; link = 1'b0; reg_write = 1'b0; reg_dst = 1'b0;
    mem_to_reg = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    read_hi_lo = 1'b0; muldiv_start = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read       = 1'b1;
          mem_byteenable = '1;
          ir_write       = !mem_waitrequest;
          pc_write       = !mem_waitrequest;
        end
        S_EXEC: begin
          branch       = d_br;
          jump         = d_j || d_jal;
          jr           = d_jr || d_jalr;
          pc_write     = d_j || d_jal || d_jr || d_jalr;
          link         = d_jal || d_jalr;
          reg_write    = d_jal || d_jalr || d_mfhi || d_mflo;
          reg_dst      = d_jalr || d_mfhi || d_mflo;
          read_hi_lo   = d_mfhi || d_mflo;
          muldiv_start = d_md;
          write_hi     = d_mthi;
          write_lo     = d_mtlo;
        end
        S_MEM: begin
          iord = 1'b1;
          if (d_load) begin
            mem_read       = 1'b1;
            mem_byteenable = '1;
          end else if (!mis_store) begin
            mem_write      = 1'b1;
            mem_byteenable = st_be;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = d_ralu;
          mem_to_reg = d_load;
        end
        S_MD_WAIT: begin
          write_hi = !muldiv_busy;
          write_lo = !muldiv_busy;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: each instruction is expanded
// into its expected per-cycle trace from the instruction-class timing rules.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        mem_waitrequest, muldiv_busy, jr_target_zero;
  logic [1:0]  addr_lo;
  logic        active, ir_write, pc_write, iord, mem_read, mem_write;
  logic [3:0]  state, mem_byteenable;
  logic        jr, jump, branch, link, reg_write, reg_dst, mem_to_reg;
  logic        write_hi, write_lo, read_hi_lo, muldiv_start, illegal;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.BYTE_LANES(4), .SUPPORT_MULDIV(1), .HALT_ON_ZERO_JR(1)) dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .mem_waitrequest(mem_waitrequest),
    .addr_lo(addr_lo), .muldiv_busy(muldiv_busy), .jr_target_zero(jr_target_zero),
    .active(active), .state(state), .ir_write(ir_write), .pc_write(pc_write),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .jr(jr), .jump(jump), .branch(branch),
    .link(link), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .write_hi(write_hi), .write_lo(write_lo), .read_hi_lo(read_hi_lo),
    .muldiv_start(muldiv_start), .illegal(illegal)
  );

  localparam logic [15:0] IRW = 16'h8000, PCW = 16'h4000, IORD = 16'h2000, MRD = 16'h1000;
  localparam logic [15:0] MWR = 16'h0800, JRS = 16'h0400, JMP = 16'h0200, BRA = 16'h0100;
  localparam logic [15:0] LNK = 16'h0080, RGW = 16'h0040, RDS = 16'h0020, M2R = 16'h0010;
  localparam logic [15:0] WHI = 16'h0008, WLO = 16'h0004, RHL = 16'h0002, MDS = 16'h0001;

  logic [15:0] sig_obs;
  assign sig_obs = {ir_write, pc_write, iord, mem_read, mem_write, jr, jump, branch,
                    link, reg_write, reg_dst, mem_to_reg, write_hi, write_lo,
                    read_hi_lo, muldiv_start};

  typedef enum int {K_RALU, K_IALU, K_LUI, K_BR, K_J, K_JAL, K_JR, K_JALR, K_MD,
                    K_MTHI, K_MTLO, K_MFHI, K_MFLO, K_LOAD, K_SW, K_SH, K_SB, K_ILL} kind_e;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] sig;
    logic [3:0]  be;
    logic        act;
    logic        ill;
    logic        wr;
    logic        busy;
    logic [1:0]  alo;
    logic        tz;
    logic [31:0] word;
  } cyc_t;

  cyc_t        exp_q[$];
  logic        m_ill;
  logic [1:0]  cur_alo;
  logic        cur_tz;
  logic [31:0] cur_word;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  logic [5:0] ralu_fn [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                               6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  logic [5:0] load_op [5]  = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  logic [5:0] ill_op  [6]  = '{6'h3F, 6'h01, 6'h06, 6'h07, 6'h10, 6'h3E};
  logic [5:0] ill_fn  [5]  = '{6'h0C, 6'h0D, 6'h3F, 6'h01, 6'h05};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void push(logic [3:0] st, logic [15:0] sig, logic [3:0] be,
                               logic wr, logic busy);
    cyc_t c;
    c.st = st; c.sig = sig; c.be = be; c.act = (st != 4'd6); c.ill = m_ill;
    c.wr = wr; c.busy = busy; c.alo = cur_alo; c.tz = cur_tz; c.word = cur_word;
    exp_q.push_back(c);
  endfunction

  function automatic logic [31:0] enc(kind_e k);
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [31:0] w;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
    imm = 16'($urandom);
    case (k)
      K_RALU: w = {6'h00, rs, rt, rd, sh, ralu_fn[$urandom_range(0, 15)]};
      K_IALU: w = {6'(8 + $urandom_range(0, 6)), rs, rt, imm};
      K_LUI:  w = {6'h0F, 5'd0, rt, imm};
      K_BR:   w = {($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, rs, rt, imm};
      K_J:    w = {6'h02, 26'($urandom)};
      K_JAL:  w = {6'h03, 26'($urandom)};
      K_JR:   w = {6'h00, rs, 15'd0, 6'h08};
      K_JALR: w = {6'h00, rs, 5'd0, rd, 5'd0, 6'h09};
      K_MD:   w = {6'h00, rs, rt, 10'd0, 6'(8'h18 + $urandom_range(0, 3))};
      K_MTHI: w = {6'h00, rs, 15'd0, 6'h11};
      K_MTLO: w = {6'h00, rs, 15'd0, 6'h13};
      K_MFHI: w = {16'd0, rd, 5'd0, 6'h10};
      K_MFLO: w = {16'd0, rd, 5'd0, 6'h12};
      K_LOAD: w = {load_op[$urandom_range(0, 4)], rs, rt, imm};
      K_SW:   w = {6'h2B, rs, rt, imm};
      K_SH:   w = {6'h29, rs, rt, imm};
      K_SB:   w = {6'h28, rs, rt, imm};
      default:
        if ($urandom_range(0, 1) != 0) w = {ill_op[$urandom_range(0, 5)], 26'($urandom)};
        else w = {6'h00, rs, rt, rd, sh, ill_fn[$urandom_range(0, 4)]};
    endcase
    return w;
  endfunction

  // Expand one instruction into its expected cycle trace.
  function automatic void plan(kind_e k, logic [31:0] w, logic [1:0] alo, logic tz,
                               int unsigned wf, int unsigned wm, int unsigned nb,
                               int unsigned ns);
    logic [15:0] xs;
    logic [3:0]  be;
    logic        ok;
    cur_word = w; cur_alo = alo; cur_tz = tz;
    for (int unsigned i = 0; i < wf; i++) push(4'd0, MRD, 4'hF, 1'b1, 1'b0);
    push(4'd0, MRD | IRW | PCW, 4'hF, 1'b0, 1'b0);
    if (k inside {K_MD, K_MTHI, K_MTLO, K_MFHI, K_MFLO}) begin
      for (int unsigned i = 0; i < ns; i++) push(4'd1, 16'h0, 4'h0, 1'b0, 1'b1);
      push(4'd1, 16'h0, 4'h0, 1'b0, 1'b0);
    end else begin
      push(4'd1, 16'h0, 4'h0, 1'b0, 1'($urandom_range(0, 1)));
    end
    case (k)
      K_BR:            xs = BRA;
      K_J:             xs = JMP | PCW;
      K_JAL:           xs = JMP | PCW | LNK | RGW;
      K_JR:            xs = JRS | PCW;
      K_JALR:          xs = JRS | PCW | LNK | RDS | RGW;
      K_MD:            xs = MDS;
      K_MTHI:          xs = WHI;
      K_MTLO:          xs = WLO;
      K_MFHI, K_MFLO:  xs = RHL | RDS | RGW;
      default:         xs = 16'h0;
    endcase
    push(4'd2, xs, 4'h0, 1'b0, 1'b0);
    if (k == K_ILL) m_ill = 1'b1;
    case (k)
      K_RALU:        push(4'd4, RGW | RDS, 4'h0, 1'b0, 1'b0);
      K_IALU, K_LUI: push(4'd4, RGW, 4'h0, 1'b0, 1'b0);
      K_LOAD: begin
        for (int unsigned i = 0; i < wm; i++) push(4'd3, IORD | MRD, 4'hF, 1'b1, 1'b0);
        push(4'd3, IORD | MRD, 4'hF, 1'b0, 1'b0);
        push(4'd4, RGW | M2R, 4'h0, 1'b0, 1'b0);
      end
      K_SW, K_SH, K_SB: begin
        if (k == K_SW)      begin ok = (alo == 2'd0); be = 4'hF; end
        else if (k == K_SH) begin ok = !alo[0]; be = alo[1] ? 4'hC : 4'h3; end
        else                begin ok = 1'b1; be = 4'(1 << alo); end
        if (ok) begin
          for (int unsigned i = 0; i < wm; i++) push(4'd3, IORD | MWR, be, 1'b1, 1'b0);
          push(4'd3, IORD | MWR, be, 1'b0, 1'b0);
        end else begin
          push(4'd3, IORD, 4'h0, 1'b0, 1'b0);
          m_ill = 1'b1;
        end
      end
      K_MD: begin
        for (int unsigned i = 0; i < nb; i++) push(4'd5, 16'h0, 4'h0, 1'b0, 1'b1);
        push(4'd5, WHI | WLO, 4'h0, 1'b0, 1'b0);
      end
      K_JR: if (tz) for (int unsigned i = 0; i < 3; i++) push(4'd6, 16'h0, 4'h0, 1'b0, 1'b0);
      default: ;
    endcase
  endfunction

  task automatic run_all();
    cyc_t c;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      mem_waitrequest = c.wr; muldiv_busy = c.busy; addr_lo = c.alo;
      jr_target_zero = c.tz; instr = c.word;
      #1;
      check_eq("state",   32'(state),          32'(c.st));
      check_eq("strobes", 32'(sig_obs),        32'(c.sig));
      check_eq("byteen",  32'(mem_byteenable), 32'(c.be));
      check_eq("active",  32'(active),         32'(c.act));
      check_eq("illegal", 32'(illegal),        32'(c.ill));
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_state"},   32'(state),          32'd0);
    check_eq({tag, "_strobes"}, 32'(sig_obs),        32'd0);
    check_eq({tag, "_byteen"},  32'(mem_byteenable), 32'd0);
    check_eq({tag, "_active"},  32'(active),         32'd1);
    check_eq({tag, "_illegal"}, 32'(illegal),        32'd0);
  endtask

  initial begin
    kind_e k;
    logic  tz;
    reset_n = 1'b0; instr = '0; mem_waitrequest = 1'b0; muldiv_busy = 1'b0;
    addr_lo = '0; jr_target_zero = 1'b0; m_ill = 1'b0;
    cur_alo = '0; cur_tz = 1'b0; cur_word = '0;
    #12;
    check_reset_state("reset");
    @(negedge clk);
    reset_n = 1'b1;

    plan(K_RALU, 32'h00221821, 2'd0, 1'b0, 0, 0, 0, 0);
    plan(K_LOAD, 32'h8C220000, 2'd0, 1'b0, 0, 3, 0, 0);
    plan(K_SB,   32'hA0220000, 2'd2, 1'b0, 0, 0, 0, 0);
    plan(K_SH,   32'hA4220000, 2'd1, 1'b0, 0, 0, 0, 0);
    plan(K_MD,   32'h00220018, 2'd0, 1'b0, 0, 0, 5, 0);
    plan(K_MFHI, 32'h00001010, 2'd0, 1'b0, 0, 0, 0, 3);
    plan(K_ILL,  32'hFC000000, 2'd0, 1'b0, 0, 0, 0, 0);
    plan(K_SW,   32'hAC220000, 2'd0, 1'b0, 1, 2, 0, 0);
    for (int n = 0; n < 250; n++) begin
      k  = kind_e'($urandom_range(0, 17));
      tz = (k == K_JR) ? 1'b0 : 1'($urandom_range(0, 1));
      plan(k, enc(k), 2'($urandom), tz, $urandom_range(0, 2), $urandom_range(0, 2),
           $urandom_range(0, 4), $urandom_range(0, 3));
    end
    plan(K_JR, 32'h00000008, 2'd0, 1'b1, 0, 0, 0, 0);
    run_all();

    // Asynchronous reset while parked in HALT.
    #3 reset_n = 1'b0;
    #1;
    m_ill = 1'b0;
    check_reset_state("halt_reset");
    @(negedge clk);
    reset_n = 1'b1;
    plan(K_RALU, 32'h00221821, 2'd0, 1'b0, 0, 0, 0, 0);
    run_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
